// File: rtl/spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// spike_rate_encoder
// Captures one frame of N_PIX grayscale pixels and turns it into N_STEPS
// binary spike vectors using deterministic sigma-delta rate coding. Each
// vector is offered on a valid/ready handshake, one timestep per transfer.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active-low
//   load         : capture pixel_in and start a frame (idle only)
//   abort        : cancel the current frame (wins over load and transfer)
//   pixel_in     : N_PIX pixels, pixel i at [i*PIX_W +: PIX_W]
//   spike_ready  : downstream accepts the presented vector
//   spike_valid  : spike_out holds a valid timestep vector
//   spike_out    : bit i = spike of pixel i for this timestep
//   step_idx     : index of the presented timestep
//   busy         : frame in progress
//   frame_done   : one-cycle pulse after the last timestep is accepted
// ---------------------------------------------------------------------------
module spike_rate_encoder #(
  parameter int N_PIX   = 16,
  parameter int PIX_W   = 8,
  parameter int N_STEPS = 16,
  localparam int STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   abort,
  input  logic [N_PIX*PIX_W-1:0] pixel_in,
  input  logic                   spike_ready,
  output logic                   spike_valid,
  output logic [N_PIX-1:0]       spike_out,
  output logic [STEP_W-1:0]      step_idx,
  output logic                   busy,
  output logic                   frame_done
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  state_t           state;
  logic [PIX_W-1:0] pix_r [N_PIX];
  logic [PIX_W-1:0] acc   [N_PIX];
  logic [PIX_W:0]   sum   [N_PIX];
  logic [STEP_W-1:0] step_r;
  logic              frame_done_r;
  logic              xfer;

  // One sigma-delta step: the carry out of the accumulator is the spike,
  // the low PIX_W bits are the residue carried into the next timestep.
  function automatic logic [PIX_W:0] sd_sum(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] p);
    return {1'b0, a} + {1'b0, p};
  endfunction

  // Spike vector is a pure function of registered state.
  always_comb begin
    spike_out = '0;
    for (int i = 0; i < N_PIX; i++) begin
      sum[i]       = sd_sum(acc[i], pix_r[i]);
      spike_out[i] = (state == EMIT) && sum[i][PIX_W];
    end
  end

  assign spike_valid = (state == EMIT);
  assign busy        = (state == EMIT);
  assign step_idx    = step_r;
  assign frame_done  = frame_done_r;
  assign xfer        = spike_valid && spike_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      step_r       <= '0;
      frame_done_r <= 1'b0;
      for (int i = 0; i < N_PIX; i++) begin
        pix_r[i] <= '0;
        acc[i]   <= '0;
      end
    end else begin
      frame_done_r <= 1'b0;
      case (state)
        IDLE: begin
          // abort in IDLE does nothing but still suppresses a load
          if (load && !abort) begin
            state  <= EMIT;
            step_r <= '0;
            for (int i = 0; i < N_PIX; i++) begin
              pix_r[i] <= pixel_in[i*PIX_W +: PIX_W];
              acc[i]   <= '0;
            end
          end
        end
        EMIT: begin
          if (abort) begin
            state  <= IDLE;
            step_r <= '0;
            for (int i = 0; i < N_PIX; i++) acc[i] <= '0;
          end else if (xfer) begin
            for (int i = 0; i < N_PIX; i++) acc[i] <= sum[i][PIX_W-1:0];
            if (step_r == LAST_STEP) begin
              state        <= IDLE;
              step_r       <= '0;
              frame_done_r <= 1'b1;
            end else begin
              step_r <= step_r + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
